// File: rtl/ch9350_led_tx_if.sv
// LED-request handshake between host logic and the CH9350 LED transmitter.
interface ch9350_led_tx_if;
  logic [2:0] leds;
  logic       leds_valid;
  logic       leds_ready;

  modport master (output leds, output leds_valid, input  leds_ready);
  modport slave  (input  leds, input  leds_valid, output leds_ready);
endinterface

// File: rtl/ch9350_led_tx.sv
// CH9350 LED command transmitter: latches an LED request and sends
// 57 AB CMD LED CHK as back-to-back 8N1 bytes on the CH9350 RXD pin.
module ch9350_led_tx #(
  parameter int unsigned PRESCALE = 39,
  parameter logic [7:0]  CMD_LED  = 8'h12
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  ch9350_led_tx_if.slave    led_req,
  output logic              o_txd,
  output logic              o_busy
);

  localparam int unsigned BIT_CYCLES = PRESCALE * 8;
  localparam int unsigned CW         = $clog2(BIT_CYCLES);
  localparam logic [CW-1:0] BIT_MAX  = CW'(BIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [2:0]  bit_idx, bit_nx;
  logic [2:0]  byte_idx, byte_nx;
  logic [2:0]  led_q;
  logic        accept;
  logic        txd_nx;
  logic [7:0]  frame_byte;

  assign accept             = (state == IDLE) && led_req.leds_valid;
  assign led_req.leds_ready = (state == IDLE);
  assign o_busy             = (state != IDLE);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      led_q    <= '0;
      o_txd    <= 1'b1;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      bit_idx  <= bit_nx;
      byte_idx <= byte_nx;
      o_txd    <= txd_nx;
      if (accept) led_q <= led_req.leds;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    bit_nx   = bit_idx;
    byte_nx  = byte_idx;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nx = START;
          cnt_nx   = BIT_MAX;
          bit_nx   = '0;
          byte_nx  = '0;
        end
      end
      START: begin
        if (cnt == '0) begin
          state_nx = DATA;
          cnt_nx   = BIT_MAX;
          bit_nx   = '0;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      DATA: begin
        if (cnt == '0) begin
          cnt_nx = BIT_MAX;
          if (bit_idx == 3'd7) state_nx = STOP;
          else                 bit_nx   = bit_idx + 1'b1;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      STOP: begin
        if (cnt == '0) begin
          if (byte_idx == 3'd4) begin
            state_nx = IDLE;
            byte_nx  = '0;
          end else begin
            state_nx = START;
            cnt_nx   = BIT_MAX;
            byte_nx  = byte_idx + 1'b1;
          end
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Line level is computed from the next state so o_txd can be a plain register
  // that already shows the start bit on the acceptance edge.
  always_comb begin
    frame_byte = 8'h57;
    unique case (byte_nx)
      3'd0:    frame_byte = 8'h57;
      3'd1:    frame_byte = 8'hAB;
      3'd2:    frame_byte = CMD_LED;
      3'd3:    frame_byte = {5'b0, led_q};
      3'd4:    frame_byte = CMD_LED + {5'b0, led_q};
      default: frame_byte = 8'h57;
    endcase
  end

  always_comb begin
    txd_nx = 1'b1;
    unique case (state_nx)
      START:   txd_nx = 1'b0;
      DATA:    txd_nx = frame_byte[bit_nx];
      default: txd_nx = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_ch9350_led_tx.sv
// Directed bench for ch9350_led_tx: exact bit timing, frame contents, handshake and reset abort.
module tb_ch9350_led_tx;

  logic clk = 1'b0;
  logic rst_n;
  logic txd, busy, txd_w, busy_w;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  ch9350_led_tx_if bus ();
  ch9350_led_tx_if bus_w ();

  ch9350_led_tx dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .led_req (bus),
    .o_txd   (txd),
    .o_busy  (busy)
  );

  ch9350_led_tx #(.PRESCALE(2), .CMD_LED(8'hFE)) dut_w (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .led_req (bus_w),
    .o_txd   (txd_w),
    .o_busy  (busy_w)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit w, input logic [2:0] leds, input logic valid);
    if (w) begin bus_w.leds = leds; bus_w.leds_valid = valid; end
    else   begin bus.leds   = leds; bus.leds_valid   = valid; end
  endtask

  // Called #1 after an edge. Requests a frame, waits for acceptance, then samples
  // the first and last cycle of every bit and the handshake around the frame end.
  task automatic run_frame(input bit w, input logic [2:0] leds, input logic [2:0] alt,
                           input bit hold, input logic [39:0] exp, input string nm,
                           output int waited);
    int P;
    int busy_bad;
    bit ok;
    logic rdy, line;
    logic [9:0] first [5];
    logic [9:0] last  [5];
    P = w ? 16 : 312;
    drive(w, leds, 1'b1);
    waited = 0;
    ok = 1'b0;
    for (int t = 0; t < 100; t++) begin
      rdy = w ? bus_w.leds_ready : bus.leds_ready;
      @(posedge clk); #1;
      if (rdy) begin ok = 1'b1; break; end
      waited++;
    end
    check({nm, " accepted"}, 32'(ok), 32'd1);
    if (!ok) return;
    check({nm, " ready_drop"}, 32'(w ? bus_w.leds_ready : bus.leds_ready), 32'd0);
    if (!hold) drive(w, leds, 1'b0);
    busy_bad = 0;
    for (int c = 0; c < 50 * P; c++) begin
      line = w ? txd_w : txd;
      if (c % P == 0)     first[c / (P * 10)][(c / P) % 10] = line;
      if (c % P == P - 1) last[c / (P * 10)][(c / P) % 10]  = line;
      if (!(w ? busy_w : busy)) busy_bad++;
      if (c == P * 20) drive(w, alt, hold);
      if (c == 50 * P - 1)
        check({nm, " ready_late"}, 32'(w ? bus_w.leds_ready : bus.leds_ready), 32'd0);
      @(posedge clk); #1;
    end
    for (int k = 0; k < 5; k++) begin
      check($sformatf("%s byte%0d first", nm, k), 32'(first[k]), 32'({1'b1, exp[39 - 8 * k -: 8], 1'b0}));
      check($sformatf("%s byte%0d last", nm, k),  32'(last[k]),  32'({1'b1, exp[39 - 8 * k -: 8], 1'b0}));
    end
    check({nm, " busy_during"}, 32'(busy_bad), 32'd0);
    check({nm, " ready_back"}, 32'(w ? bus_w.leds_ready : bus.leds_ready), 32'd1);
    check({nm, " busy_end"}, 32'(w ? busy_w : busy), 32'd0);
    check({nm, " txd_idle_gap"}, 32'(w ? txd_w : txd), 32'd1);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bad, wt;
    rst_n = 1'b0;
    drive(0, 3'b000, 1'b0);
    drive(1, 3'b000, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("rst txd",   32'(txd),            32'd1);
    check("rst ready", 32'(bus.leds_ready), 32'd1);
    check("rst busy",  32'(busy),           32'd0);
    check("rst_w txd", 32'(txd_w),          32'd1);
    rst_n = 1'b1;

    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      if (txd !== 1'b1 || bus.leds_ready !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("idle 1000", 32'(bad), 32'd0);

    run_frame(1'b1, 3'b011, 3'b011, 1'b0, {8'h57, 8'hAB, 8'hFE, 8'h03, 8'h01}, "wrap", wt);
    run_frame(1'b0, 3'b010, 3'b010, 1'b0, {8'h57, 8'hAB, 8'h12, 8'h02, 8'h14}, "caps", wt);
    run_frame(1'b0, 3'b111, 3'b000, 1'b0, {8'h57, 8'hAB, 8'h12, 8'h07, 8'h19}, "all_chg", wt);

    // Reset during the data bits of the LED byte.
    drive(0, 3'b101, 1'b1);
    @(posedge clk); #1;
    drive(0, 3'b101, 1'b0);
    repeat (10072) @(posedge clk);
    #1;
    check("abort pre busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort txd",   32'(txd),            32'd1);
    check("abort ready", 32'(bus.leds_ready), 32'd1);
    check("abort busy",  32'(busy),           32'd0);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (txd !== 1'b1) bad++;
    end
    check("abort no resume", 32'(bad), 32'd0);

    run_frame(1'b0, 3'b001, 3'b100, 1'b1, {8'h57, 8'hAB, 8'h12, 8'h01, 8'h13}, "b2b_1", wt);
    run_frame(1'b0, 3'b100, 3'b100, 1'b0, {8'h57, 8'hAB, 8'h12, 8'h04, 8'h16}, "b2b_2", wt);
    check("b2b accept wait", 32'(wt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
